// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, per-burst arbiter sharing the fifod byte write port between two writers.
// Optional idle-beat watchdog is compiled in when FIFO_WR_ARB_TIMEOUT_EN is defined.
module fifo_wr_arb #(
    parameter int DW     = 8,
    parameter int LW     = 12,
    parameter int TO_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs0,
    input  logic          fs1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic          wen0,
    input  logic          wen1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          fd0,
    output logic          fd1,
    output logic          fifo_txen,
    output logic [DW-1:0] fifo_txd,
    input  logic          fifo_full,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_DONE} state_t;

    state_t        r_state;
    logic          r_last;
    logic [LW-1:0] r_cnt;
    logic [LW-1:0] r_len;

    logic          w_gnt_st;
    logic          w_sel1;
    logic          w_wen;
    logic [DW-1:0] w_wd;
    logic          w_zero;
    logic          w_acc;
    logic          w_drop;
    logic          w_to;
    logic          w_end;

    // Only the granted requester's strobe/data reach the FIFO path.
    assign w_gnt_st = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_sel1   = (r_state == S_GNT1);
    assign w_wen    = w_sel1 ? wen1 : wen0;
    assign w_wd     = w_sel1 ? wd1 : wd0;
    assign w_zero   = (r_len == '0);
    assign w_acc    = w_gnt_st & ~w_zero & w_wen & ~fifo_full;
    assign w_drop   = w_gnt_st & ~w_zero & w_wen & fifo_full;
    assign w_end    = w_gnt_st & (w_zero | w_to | (w_acc & (r_cnt == r_len - LW'(1))));

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TO_CYC + 1);
    logic [WDW-1:0] r_wd;

    assign w_to = w_gnt_st & ~w_acc & ~w_zero & (r_wd == WDW'(TO_CYC - 1));

    // Cleared outside GNT, so every new grant starts a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wd <= '0;
        else if (!w_gnt_st || w_acc)
            r_wd <= '0;
        else
            r_wd <= r_wd + WDW'(1);
    end
`else
    // TO_CYC only matters when the watchdog is built in.
    assign w_to = 1'b0 & (TO_CYC > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_len     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            fd0       <= 1'b0;
            fd1       <= 1'b0;
            fifo_txen <= 1'b0;
            fifo_txd  <= '0;
            err       <= 1'b0;
        end else begin
            fifo_txen <= w_acc;
            if (w_acc)
                fifo_txd <= w_wd;
            if (w_drop || w_to)
                err <= 1'b1;
            fd0 <= 1'b0;
            fd1 <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // On a tie the requester not served last wins.
                    if (fs0 && (!fs1 || r_last)) begin
                        r_state <= S_GNT0;
                        gnt0    <= 1'b1;
                        r_len   <= len0;
                        r_last  <= 1'b0;
                    end else if (fs1) begin
                        r_state <= S_GNT1;
                        gnt1    <= 1'b1;
                        r_len   <= len1;
                        r_last  <= 1'b1;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (w_acc)
                        r_cnt <= r_cnt + LW'(1);
                    if (w_end) begin
                        r_state <= S_DONE;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        fd0     <= ~w_sel1;
                        fd1     <= w_sel1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
